ball_flight: RTL and testbench

BALL_FLIGHT -- requirements
Module: ball_flight

---
 rtl/ball_flight.sv | 106 ++++++++++
 tb/tb_ball_flight.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_flight.sv
// Projectile integrator: fixed-point position/velocity stepped once per tick,
// stopping on ground contact or when the ball reaches the right-hand wall.
module ball_flight #(
    parameter int GRAVITY = 16,
    parameter int FRAC    = 4,
    parameter int X_MAX   = 639
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       launch,
    input  logic       tick,
    input  logic [9:0] Vel_x,
    input  logic [9:0] Vel_y,
    output logic [9:0] Pos_x,
    output logic [9:0] Pos_y,
    output logic       busy,
    output logic       done,
    output logic       hit_wall
);

    typedef enum logic [1:0] {IDLE, FLIGHT, LAND} state_t;

    localparam logic [15:0]        PX_LIM = 16'(X_MAX << FRAC);
    localparam logic signed [11:0] GRAV   = 12'(GRAVITY);

    state_t             state, state_d;
    logic [9:0]         vx, vx_d;
    logic signed [11:0] vy, vy_d;
    logic [14:0]        px, px_d;
    logic signed [16:0] py, py_d;
    logic               hw_d;
    logic [15:0]        next_px;
    logic [17:0]        next_py;
    logic [14:0]        px_int;
    logic [16:0]        py_int;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            vx       <= '0;
            vy       <= '0;
            px       <= '0;
            py       <= '0;
            hit_wall <= 1'b0;
        end else begin
            state    <= state_d;
            vx       <= vx_d;
            vy       <= vy_d;
            px       <= px_d;
            py       <= py_d;
            hit_wall <= hw_d;
        end
    end

    always_comb begin
        state_d = state;
        vx_d    = vx;
        vy_d    = vy;
        px_d    = px;
        py_d    = py;
        hw_d    = hit_wall;
        // One bit of headroom on each sum so overflow past the wall or
        // below ground is visible before clamping.
        next_px = {1'b0, px} + {6'b0, vx};
        next_py = {py[16], py} + {{6{vy[11]}}, vy};
        case (state)
            IDLE: begin
                if (launch) begin
                    vx_d    = Vel_x;
                    vy_d    = {2'b00, Vel_y};
                    px_d    = '0;
                    py_d    = '0;
                    hw_d    = 1'b0;
                    state_d = FLIGHT;
                end
            end
            FLIGHT: begin
                if (tick) begin
                    vy_d = vy - GRAV;
                    px_d = next_px[14:0];
                    py_d = next_py[16:0];
                    if (next_py[17]) begin
                        py_d    = '0;
                        state_d = LAND;
                    end
                    if (next_px > PX_LIM) begin
                        px_d    = PX_LIM[14:0];
                        hw_d    = 1'b1;
                        state_d = LAND;
                    end
                end
            end
            LAND:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // py is never negative once stored, so a logical shift gives the pixel row.
    assign px_int = px >> FRAC;
    assign py_int = py >> FRAC;
    assign Pos_x  = (|px_int[14:10]) ? 10'h3ff : px_int[9:0];
    assign Pos_y  = (|py_int[16:10]) ? 10'h3ff : py_int[9:0];
    assign busy   = (state == FLIGHT);
    assign done   = (state == LAND);

endmodule

// File: tb/tb_ball_flight.sv
// Directed bench for ball_flight: reset, arc, flat shot, wall hit, ignored
// launches and consecutive flights, with hand-computed expectations.
module tb_ball_flight;

    logic       clk = 1'b0;
    logic       rst_n, launch, tick;
    logic [9:0] Vel_x, Vel_y;
    logic [9:0] Pos_x, Pos_y;
    logic       busy, done, hit_wall;
    int         tests = 0;
    int         fails = 0;

    ball_flight #(.GRAVITY(16), .FRAC(4), .X_MAX(639)) dut (
        .clk(clk), .rst_n(rst_n), .launch(launch), .tick(tick),
        .Vel_x(Vel_x), .Vel_y(Vel_y), .Pos_x(Pos_x), .Pos_y(Pos_y),
        .busy(busy), .done(done), .hit_wall(hit_wall)
    );

    always #5 clk = ~clk;

    // Stimulus changes right after a falling edge; outputs are read at the
    // following falling edge, one rising edge later.
    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_launch(input logic [9:0] vx, input logic [9:0] vy);
        @(negedge clk);
        Vel_x  = vx;
        Vel_y  = vy;
        launch = 1'b1;
        @(negedge clk);
        launch = 1'b0;
        Vel_x  = 10'd0;
        Vel_y  = 10'd0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        launch = 1'b1;
        Vel_x = 10'd100;
        Vel_y = 10'd100;
        idle_cycle();
        idle_cycle();
        launch = 1'b0;
        tests++;
        if ({Pos_x, Pos_y, busy, done, hit_wall} !== 23'd0) begin
            fails++;
            $display("FAIL reset_outputs got x=%0d y=%0d b=%0b d=%0b w=%0b exp all 0",
                     Pos_x, Pos_y, busy, done, hit_wall);
        end
        rst_n = 1'b1;
        idle_cycle();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_launch_discarded busy got %0b exp 0", busy);
        end
    endtask

    task automatic test_arc();
        int ey[6] = '{2, 3, 3, 2, 0, 0};
        do_launch(10'd160, 10'd32);
        tests++;
        if (busy !== 1'b1 || Pos_x !== 10'd0) begin
            fails++;
            $display("FAIL arc_launch got busy=%0b x=%0d exp busy=1 x=0", busy, Pos_x);
        end
        for (int i = 0; i < 6; i++) begin
            do_tick();
            tests++;
            if (Pos_y !== 10'(ey[i]) || Pos_x !== 10'(10 * (i + 1)) ||
                done !== (i == 5)) begin
                fails++;
                $display("FAIL arc_tick%0d got x=%0d y=%0d done=%0b exp x=%0d y=%0d done=%0b",
                         i + 1, Pos_x, Pos_y, done, 10 * (i + 1), ey[i], i == 5);
            end
        end
        idle_cycle();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || hit_wall !== 1'b0 || Pos_x !== 10'd60) begin
            fails++;
            $display("FAIL arc_end got done=%0b busy=%0b wall=%0b x=%0d exp 0 0 0 60",
                     done, busy, hit_wall, Pos_x);
        end
    endtask

    task automatic test_flat();
        do_launch(10'd16, 10'd0);
        do_tick();
        tests++;
        if (Pos_y !== 10'd0 || busy !== 1'b1 || Pos_x !== 10'd1) begin
            fails++;
            $display("FAIL flat_tick1 got y=%0d busy=%0b x=%0d exp y=0 busy=1 x=1",
                     Pos_y, busy, Pos_x);
        end
        do_tick();
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || Pos_x !== 10'd2 || Pos_y !== 10'd0) begin
            fails++;
            $display("FAIL flat_land got done=%0b busy=%0b x=%0d y=%0d exp 1 0 2 0",
                     done, busy, Pos_x, Pos_y);
        end
        idle_cycle();
    endtask

    task automatic test_wall();
        do_launch(10'd717, 10'd717);
        for (int i = 0; i < 14; i++) do_tick();
        tests++;
        if (Pos_x !== 10'd627 || Pos_y !== 10'd536 || busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL wall_tick14 got x=%0d y=%0d busy=%0b done=%0b exp 627 536 1 0",
                     Pos_x, Pos_y, busy, done);
        end
        do_tick();
        tests++;
        if (Pos_x !== 10'd639 || Pos_y !== 10'd567 || hit_wall !== 1'b1 || done !== 1'b1) begin
            fails++;
            $display("FAIL wall_hit got x=%0d y=%0d wall=%0b done=%0b exp 639 567 1 1",
                     Pos_x, Pos_y, hit_wall, done);
        end
        idle_cycle();
        do_tick();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || hit_wall !== 1'b1 ||
            Pos_x !== 10'd639 || Pos_y !== 10'd567) begin
            fails++;
            $display("FAIL wall_hold got done=%0b busy=%0b wall=%0b x=%0d y=%0d exp 0 0 1 639 567",
                     done, busy, hit_wall, Pos_x, Pos_y);
        end
    endtask

    task automatic test_back_to_back();
        do_launch(10'd717, 10'd717);
        for (int i = 0; i < 15; i++) do_tick();
        idle_cycle();
        tests++;
        if (hit_wall !== 1'b1) begin
            fails++;
            $display("FAIL b2b_wall_set got %0b exp 1", hit_wall);
        end
        do_launch(10'd160, 10'd32);
        tests++;
        if (hit_wall !== 1'b0 || Pos_x !== 10'd0 || Pos_y !== 10'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_relaunch got wall=%0b x=%0d y=%0d busy=%0b exp 0 0 0 1",
                     hit_wall, Pos_x, Pos_y, busy);
        end
        for (int i = 0; i < 6; i++) do_tick();
        tests++;
        if (done !== 1'b1 || hit_wall !== 1'b0 || Pos_x !== 10'd60) begin
            fails++;
            $display("FAIL b2b_second_land got done=%0b wall=%0b x=%0d exp 1 0 60",
                     done, hit_wall, Pos_x);
        end
        idle_cycle();
    endtask

    task automatic test_launch_ignore();
        do_launch(10'd160, 10'd32);
        do_tick();
        do_launch(10'd16, 10'd0);
        do_tick();
        do_tick();
        tests++;
        if (Pos_x !== 10'd30 || Pos_y !== 10'd3 || busy !== 1'b1) begin
            fails++;
            $display("FAIL ignore_midflight got x=%0d y=%0d busy=%0b exp 30 3 1",
                     Pos_x, Pos_y, busy);
        end
        for (int i = 0; i < 3; i++) do_tick();
        tests++;
        if (done !== 1'b1 || Pos_x !== 10'd60) begin
            fails++;
            $display("FAIL ignore_land got done=%0b x=%0d exp 1 60", done, Pos_x);
        end
        idle_cycle();
        // launch and tick together: only the launch takes effect
        @(negedge clk);
        Vel_x = 10'd16;
        Vel_y = 10'd0;
        launch = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        launch = 1'b0;
        tick = 1'b0;
        tests++;
        if (Pos_x !== 10'd0 || Pos_y !== 10'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL launch_tick_same got x=%0d y=%0d busy=%0b exp 0 0 1",
                     Pos_x, Pos_y, busy);
        end
        do_tick();
        tests++;
        if (Pos_x !== 10'd1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL launch_tick_next got x=%0d busy=%0b exp 1 1", Pos_x, busy);
        end
        do_tick();
        idle_cycle();
    endtask

    task automatic test_reset_midflight();
        do_launch(10'd160, 10'd32);
        do_tick();
        do_tick();
        @(negedge clk);
        rst_n = 1'b0;
        idle_cycle();
        idle_cycle();
        rst_n = 1'b1;
        tests++;
        if ({Pos_x, Pos_y, busy, done, hit_wall} !== 23'd0) begin
            fails++;
            $display("FAIL midflight_reset got x=%0d y=%0d b=%0b d=%0b w=%0b exp all 0",
                     Pos_x, Pos_y, busy, done, hit_wall);
        end
        do_tick();
        tests++;
        if (Pos_x !== 10'd0 || Pos_y !== 10'd0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL midflight_reset_tick got x=%0d y=%0d b=%0b d=%0b exp 0 0 0 0",
                     Pos_x, Pos_y, busy, done);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        launch = 1'b0;
        tick   = 1'b0;
        Vel_x  = 10'd0;
        Vel_y  = 10'd0;
        test_reset();
        test_arc();
        test_flat();
        test_wall();
        test_back_to_back();
        test_launch_ignore();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
